// File: rtl/core_dispatch.sv
// Event dispatcher between the priority queue and the core array: hands queue heads to
// idle cores, collects returned events round-robin and pushes them back into the queue.
module core_dispatch #(
    parameter int unsigned NUM_CORE  = 4,
    parameter int unsigned NB_COREID = $clog2(NUM_CORE),
    parameter int unsigned MSG_WID   = 32,
    parameter int unsigned TIME_WID  = 16,
    parameter int unsigned CNT_WID   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [TIME_WID-1:0]         end_time,
    input  logic                        q_empty,
    input  logic [MSG_WID-1:0]          q_head,
    output logic                        q_deq,
    input  logic                        q_full,
    output logic                        q_enq,
    output logic [MSG_WID-1:0]          q_enq_data,
    input  logic [NUM_CORE-1:0]         core_req,
    input  logic [NUM_CORE*MSG_WID-1:0] core_out_msg,
    output logic [NUM_CORE-1:0]         core_ack,
    output logic [NUM_CORE-1:0]         core_in_vld,
    output logic [MSG_WID-1:0]          core_in_msg,
    output logic [MSG_WID-1:0]          mon_msg,
    output logic                        mon_sent_vld,
    output logic                        mon_rcv_vld,
    output logic [NB_COREID-1:0]        mon_core_id,
    output logic [NUM_CORE-1:0]         core_active,
    output logic [CNT_WID-1:0]          events_sent,
    output logic                        sim_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RCV  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_armed;
    logic [MSG_WID-1:0]    r_msg;
    logic [NB_COREID-1:0]  r_id;
    logic [NB_COREID-1:0]  r_rr_ptr;
    logic [NUM_CORE-1:0]   r_core_active;
    logic [CNT_WID-1:0]    r_events_sent;
    logic                  r_sim_done;

    logic [MSG_WID-1:0]    w_out_msg [NUM_CORE];
    logic [NUM_CORE-1:0]   w_req;
    logic [NUM_CORE-1:0]   w_idle;
    logic [NB_COREID-1:0]  w_scan_id;
    logic [NB_COREID-1:0]  w_grant_id;
    logic                  w_grant_found;
    logic [NB_COREID-1:0]  w_free_id;
    logic                  w_free_found;
    logic                  w_head_blocked;
    logic                  w_can_dispatch;
    logic                  w_take_rcv;
    logic                  w_take_send;
    logic                  w_rcv_done;
    logic                  w_done_set;

    for (genvar g = 0; g < NUM_CORE; g++) begin : g_unpack
        assign w_out_msg[g] = core_out_msg[g*MSG_WID +: MSG_WID];
    end

    // Round-robin scan of eligible returns starting at r_rr_ptr; index arithmetic wraps
    // naturally because NUM_CORE is a power of two.
    always_comb begin
        w_req         = core_req & r_core_active;
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_scan_id     = '0;
        for (int unsigned k = 0; k < NUM_CORE; k++) begin
            w_scan_id = r_rr_ptr + NB_COREID'(k);
            if (!w_grant_found && w_req[w_scan_id]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_scan_id;
            end
        end
    end

    // Lowest-index idle core
    always_comb begin
        w_idle       = ~r_core_active;
        w_free_found = 1'b0;
        w_free_id    = '0;
        for (int unsigned k = 0; k < NUM_CORE; k++) begin
            if (!w_free_found && w_idle[k]) begin
                w_free_found = 1'b1;
                w_free_id    = NB_COREID'(k);
            end
        end
    end

    assign w_head_blocked = q_empty || (q_head[TIME_WID-1:0] >= end_time);
    assign w_can_dispatch = !w_head_blocked && w_free_found && !r_sim_done;
    assign w_done_set     = (r_state == IDLE) && (r_core_active == '0) && w_head_blocked;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_take_rcv   = 1'b0;
        w_take_send  = 1'b0;
        w_rcv_done   = 1'b0;
        q_deq        = 1'b0;
        q_enq        = 1'b0;
        q_enq_data   = '0;
        core_ack     = '0;
        core_in_vld  = '0;
        core_in_msg  = '0;
        mon_msg      = '0;
        mon_sent_vld = 1'b0;
        mon_rcv_vld  = 1'b0;
        mon_core_id  = '0;
        case (r_state)
            IDLE: begin
                // r_armed suppresses any decision on the first cycle out of reset
                if (r_armed) begin
                    if (w_grant_found) begin
                        w_take_rcv   = 1'b1;
                        w_state_next = RCV;
                    end else if (w_can_dispatch) begin
                        q_deq        = 1'b1;
                        w_take_send  = 1'b1;
                        w_state_next = SEND;
                    end
                end
            end
            RCV: begin
                if (!q_full) begin
                    w_rcv_done     = 1'b1;
                    q_enq          = 1'b1;
                    q_enq_data     = r_msg;
                    core_ack[r_id] = 1'b1;
                    mon_rcv_vld    = 1'b1;
                    mon_msg        = r_msg;
                    mon_core_id    = r_id;
                    w_state_next   = IDLE;
                end
            end
            SEND: begin
                core_in_vld[r_id] = 1'b1;
                core_in_msg       = r_msg;
                mon_sent_vld      = 1'b1;
                mon_msg           = r_msg;
                mon_core_id       = r_id;
                w_state_next      = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Latched transaction, busy vector, counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed       <= 1'b0;
            r_msg         <= '0;
            r_id          <= '0;
            r_rr_ptr      <= '0;
            r_core_active <= '0;
            r_events_sent <= '0;
            r_sim_done    <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_take_rcv) begin
                r_msg <= w_out_msg[w_grant_id];
                r_id  <= w_grant_id;
            end
            if (w_take_send) begin
                r_msg <= q_head;
                r_id  <= w_free_id;
            end
            if (w_rcv_done) begin
                r_core_active[r_id] <= 1'b0;
                r_rr_ptr            <= r_id + NB_COREID'(1);
            end
            if (r_state == SEND) begin
                r_core_active[r_id] <= 1'b1;
                r_events_sent       <= r_events_sent + CNT_WID'(1);
            end
            if (w_done_set) begin
                r_sim_done <= 1'b1;
            end
        end
    end

    assign core_active = r_core_active;
    assign events_sent = r_events_sent;
    assign sim_done    = r_sim_done;

endmodule

// File: tb/tb_core_dispatch.sv
// Bench for core_dispatch: directed scenarios plus randomized traffic, all checked against
// a transaction-level reference model of the dispatcher and its queue/core environment.
module tb_core_dispatch;

    localparam int unsigned NUM_CORE  = 4;
    localparam int unsigned NB_COREID = 2;
    localparam int unsigned MSG_WID   = 32;
    localparam int unsigned TIME_WID  = 16;
    localparam int unsigned CNT_WID   = 32;

    logic                        clk;
    logic                        reset;
    logic [TIME_WID-1:0]         end_time;
    logic                        q_empty;
    logic [MSG_WID-1:0]          q_head;
    logic                        q_deq;
    logic                        q_full;
    logic                        q_enq;
    logic [MSG_WID-1:0]          q_enq_data;
    logic [NUM_CORE-1:0]         core_req;
    logic [NUM_CORE*MSG_WID-1:0] core_out_msg;
    logic [NUM_CORE-1:0]         core_ack;
    logic [NUM_CORE-1:0]         core_in_vld;
    logic [MSG_WID-1:0]          core_in_msg;
    logic [MSG_WID-1:0]          mon_msg;
    logic                        mon_sent_vld;
    logic                        mon_rcv_vld;
    logic [NB_COREID-1:0]        mon_core_id;
    logic [NUM_CORE-1:0]         core_active;
    logic [CNT_WID-1:0]          events_sent;
    logic                        sim_done;

    core_dispatch #(
        .NUM_CORE (NUM_CORE),
        .NB_COREID(NB_COREID),
        .MSG_WID  (MSG_WID),
        .TIME_WID (TIME_WID),
        .CNT_WID  (CNT_WID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .end_time    (end_time),
        .q_empty     (q_empty),
        .q_head      (q_head),
        .q_deq       (q_deq),
        .q_full      (q_full),
        .q_enq       (q_enq),
        .q_enq_data  (q_enq_data),
        .core_req    (core_req),
        .core_out_msg(core_out_msg),
        .core_ack    (core_ack),
        .core_in_vld (core_in_vld),
        .core_in_msg (core_in_msg),
        .mon_msg     (mon_msg),
        .mon_sent_vld(mon_sent_vld),
        .mon_rcv_vld (mon_rcv_vld),
        .mon_core_id (mon_core_id),
        .core_active (core_active),
        .events_sent (events_sent),
        .sim_done    (sim_done)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Environment: unbounded event queue, per-core returned messages, stimulus knobs
    logic [MSG_WID-1:0] envq[$];
    logic [MSG_WID-1:0] drv_msg [NUM_CORE];
    int unsigned        req_pct;
    int unsigned        full_pct;
    bit                 req_forced;
    logic [NUM_CORE-1:0] req_val;
    bit                 full_forced;
    logic               full_val;
    int unsigned        ts_max;

    // Reference model: busy set, round-robin pointer, counters, pending strobe transaction
    typedef struct {
        bit                 ret;
        int                 core;
        logic [MSG_WID-1:0] msg;
    } txn_t;

    bit                 m_act [NUM_CORE];
    int                 m_rr;
    logic [CNT_WID-1:0] m_sent;
    bit                 m_done;
    bit                 m_fresh;
    txn_t               m_pend[$];

    // Observation tallies used by the directed scenarios
    int                  obs_deq_cnt;
    int                  obs_enq_cnt;
    logic [NUM_CORE-1:0] ack_seen[$];
    logic [11:0]         strobe_acc;
    logic [NUM_CORE-1:0] last_ack;
    logic [NUM_CORE-1:0] last_in_vld;
    logic                last_enq;
    logic                last_rcv;
    logic                last_sent;
    logic [NB_COREID-1:0] last_id;

    function automatic logic [NUM_CORE-1:0] act_vec();
        logic [NUM_CORE-1:0] v;
        for (int c = 0; c < NUM_CORE; c++) v[c] = m_act[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CORE; c++) m_act[c] = 1'b0;
        m_rr    = 0;
        m_sent  = '0;
        m_done  = 1'b0;
        m_fresh = 1'b1;
        m_pend.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check 1 time unit later, advance model and env
    task automatic step();
        logic [31:0]         rnd;
        logic [NUM_CORE-1:0] e_ack, e_in;
        logic                e_deq, e_enq, e_sv, e_rv;
        logic [MSG_WID-1:0]  e_data, e_inmsg, e_mmsg;
        logic [NB_COREID-1:0] e_id;
        txn_t                t;
        bit                  found;
        bit                  any_idle;
        int                  c;
        bit                  blocked;

        q_empty = (envq.size() == 0);
        q_head  = q_empty ? $urandom() : envq[0];
        q_full  = full_forced ? full_val : ($urandom_range(99) < full_pct);
        for (int i = 0; i < NUM_CORE; i++) begin
            rnd = $urandom();
            drv_msg[i] = {rnd[31:16], 16'($urandom_range(ts_max))};
            core_out_msg[i*MSG_WID +: MSG_WID] = drv_msg[i];
            core_req[i] = req_forced ? req_val[i] : ($urandom_range(99) < req_pct);
        end
        #1;

        chk("core_active", 64'(core_active), 64'(act_vec()));
        chk("events_sent", 64'(events_sent), 64'(m_sent));
        chk("sim_done", 64'(sim_done), 64'(m_done));

        e_ack = '0; e_in = '0; e_deq = 0; e_enq = 0; e_sv = 0; e_rv = 0;
        e_data = '0; e_inmsg = '0; e_mmsg = '0; e_id = '0;
        blocked = q_empty || (q_head[TIME_WID-1:0] >= end_time);

        if (m_pend.size() != 0) begin
            t = m_pend[0];
            if (t.ret) begin
                if (!q_full) begin
                    e_enq = 1; e_data = t.msg; e_ack[t.core] = 1'b1;
                    e_rv = 1; e_mmsg = t.msg; e_id = NB_COREID'(t.core);
                    void'(m_pend.pop_front());
                    m_act[t.core] = 1'b0;
                    m_rr = (t.core + 1) % NUM_CORE;
                end
            end else begin
                e_in[t.core] = 1'b1; e_inmsg = t.msg;
                e_sv = 1; e_mmsg = t.msg; e_id = NB_COREID'(t.core);
                void'(m_pend.pop_front());
                m_act[t.core] = 1'b1;
                m_sent = m_sent + 1;
            end
        end else begin
            if (!m_fresh) begin
                found = 0;
                for (int k = 0; k < NUM_CORE; k++) begin
                    c = (m_rr + k) % NUM_CORE;
                    if (!found && core_req[c] && m_act[c]) begin
                        found = 1;
                        m_pend.push_back('{ret: 1'b1, core: c, msg: drv_msg[c]});
                    end
                end
                any_idle = (act_vec() != {NUM_CORE{1'b1}});
                if (!found && !blocked && any_idle && !m_done) begin
                    e_deq = 1;
                    c = NUM_CORE;
                    for (int k = NUM_CORE - 1; k >= 0; k--) if (!m_act[k]) c = k;
                    m_pend.push_back('{ret: 1'b0, core: c, msg: q_head});
                end
            end
            if (act_vec() == '0 && blocked) m_done = 1'b1;
        end
        m_fresh = 1'b0;

        chk("strobes", 64'({q_deq, q_enq, core_ack, core_in_vld, mon_sent_vld, mon_rcv_vld}),
            64'({e_deq, e_enq, e_ack, e_in, e_sv, e_rv}));
        chk("q_enq_data", 64'(q_enq_data), 64'(e_data));
        chk("core_in_msg", 64'(core_in_msg), 64'(e_inmsg));
        chk("mon_msg", 64'(mon_msg), 64'(e_mmsg));
        chk("mon_core_id", 64'(mon_core_id), 64'(e_id));

        obs_deq_cnt += int'(q_deq);
        obs_enq_cnt += int'(q_enq);
        if (core_ack != '0) ack_seen.push_back(core_ack);
        strobe_acc  |= {q_deq, q_enq, core_ack, core_in_vld, mon_sent_vld, mon_rcv_vld};
        last_ack    = core_ack;
        last_in_vld = core_in_vld;
        last_enq    = q_enq;
        last_rcv    = mon_rcv_vld;
        last_sent   = mon_sent_vld;
        last_id     = mon_core_id;

        if (e_deq) void'(envq.pop_front());
        if (e_enq) envq.push_back(e_data);
        @(negedge clk);
    endtask

    task automatic clear_tallies();
        obs_deq_cnt = 0;
        obs_enq_cnt = 0;
        ack_seen.delete();
        strobe_acc = '0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        clk = 1'b0; reset = 1'b1;
        end_time = 16'd100; q_empty = 1'b1; q_head = '0; q_full = 1'b0;
        core_req = '0; core_out_msg = '0;
        req_pct = 0; full_pct = 0; req_forced = 1; req_val = '0;
        full_forced = 1; full_val = 1'b0; ts_max = 50;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_strobes", 64'({q_deq, q_enq, core_ack, core_in_vld, mon_sent_vld, mon_rcv_vld}), 64'(0));
        chk("reset_state", 64'({core_active, events_sent, sim_done}), 64'(0));
        @(negedge clk);

        // Single event at t=5 goes to core 0
        envq = '{32'h0000_0005};
        apply_reset();
        clear_tallies();
        repeat (3) step();
        chk("sc1_in_vld", 64'(last_in_vld), 64'(4'b0001));
        chk("sc1_sent_vld", 64'(last_sent), 64'(1));
        chk("sc1_core_id", 64'(last_id), 64'(0));
        step();
        chk("sc1_deq_count", 64'(obs_deq_cnt), 64'(1));
        chk("sc1_active", 64'(core_active), 64'(4'b0001));
        chk("sc1_events", 64'(events_sent), 64'(1));

        // Six events, no returns: four dispatches, the rest wait
        envq.delete();
        for (int i = 0; i < 6; i++) envq.push_back(32'(10 + i));
        apply_reset();
        clear_tallies();
        repeat (20) step();
        chk("sc2_deq_count", 64'(obs_deq_cnt), 64'(4));
        chk("sc2_active", 64'(core_active), 64'(4'hF));

        // All cores request: acks round-robin 0..3
        req_val = 4'hF;
        clear_tallies();
        repeat (8) step();
        chk("sc3_ack_count", 64'(ack_seen.size()), 64'(4));
        for (int i = 0; i < 4 && i < ack_seen.size(); i++)
            chk("sc3_ack_order", 64'(ack_seen[i]), 64'(1 << i));
        chk("sc3_enq_count", 64'(obs_enq_cnt), 64'(4));
        req_val = '0;

        // Return stalled by q_full for three cycles
        envq = '{32'h0000_0007};
        apply_reset();
        repeat (4) step();
        req_val = 4'b0001; full_val = 1'b1;
        step();
        clear_tallies();
        repeat (3) step();
        chk("sc4_hold_strobes", 64'(strobe_acc), 64'(0));
        full_val = 1'b0;
        step();
        chk("sc4_ack", 64'(last_ack), 64'(4'b0001));
        chk("sc4_enq", 64'(last_enq), 64'(1));
        chk("sc4_rcv_vld", 64'(last_rcv), 64'(1));
        req_val = '0;
        repeat (6) step();

        // Head timestamp equal to end_time is never dispatched
        envq = '{32'h0000_0064};
        apply_reset();
        clear_tallies();
        repeat (5) step();
        chk("sc5_deq_count", 64'(obs_deq_cnt), 64'(0));
        chk("sc5_done", 64'(sim_done), 64'(1));
        repeat (5) step();
        chk("sc5_done_sticky", 64'(sim_done), 64'(1));

        // Asynchronous reset while in SEND
        envq = '{32'h0000_0009};
        apply_reset();
        repeat (2) step();
        #1;
        chk("sc6_in_send", 64'(core_in_vld), 64'(4'b0001));
        #1 reset = 1'b1;
        #1;
        chk("sc6_async_strobes", 64'({core_in_vld, mon_sent_vld, mon_rcv_vld, q_deq}), 64'(0));
        chk("sc6_async_data", 64'({core_in_msg, mon_msg}), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        envq.delete();
        repeat (3) step();
        chk("sc6_after_active", 64'(core_active), 64'(0));
        chk("sc6_after_events", 64'(events_sent), 64'(0));

        // Randomized traffic phases
        req_forced = 0; full_forced = 0;
        for (int p = 0; p < 6; p++) begin
            end_time = (p == 5) ? 16'd0 : ((p == 4) ? 16'hFFFF : 16'h8000);
            ts_max   = 32'h8FFF;
            req_pct  = $urandom_range(60, 10);
            full_pct = $urandom_range(50, 0);
            envq.delete();
            for (int i = 0; i < 6; i++) envq.push_back(32'($urandom_range(32'h7FFF)));
            apply_reset();
            repeat (700) step();
            apply_reset();
            repeat (700) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
